// File: rtl/ldpc_fetch_pkg.sv
// Shared types and defaults for the LDPC codeword fetch block.
// Fetch sequencing states, parameter defaults and err bit positions.
package ldpc_fetch_pkg;

  localparam int WID_DEF  = 6;
  localparam int N_CW_DEF = 9216;
  localparam int AW_DEF   = 14;
  localparam int TMO_DEF  = 4095;

  localparam int ERR_TMO  = 2;
  localparam int ERR_OVR  = 1;
  localparam int ERR_DONE = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2,
    FIN  = 2'd3
  } state_t;

endpackage

// File: rtl/ldpc_bank_ctrl.sv
// Ping-pong bank bookkeeping: which bank is filled next, which bank the decoder reads,
// and which banks currently hold a complete codeword.
module ldpc_bank_ctrl (
  input  logic clk,
  input  logic rst_n,
  input  logic fin,
  input  logic dec_done,
  output logic wr_bank,
  output logic wr_full,
  output logic rd_bank,
  output logic dec_vld,
  output logic done_err
);

  logic [1:0] bank_full;
  logic [1:0] full_nxt;

  assign dec_vld = bank_full[rd_bank];
  assign wr_full = bank_full[wr_bank];

  // Clear is applied before set, so a set on the same bank wins.
  always_comb begin
    full_nxt = bank_full;
    if (dec_done && dec_vld) full_nxt[rd_bank] = 1'b0;
    if (fin)                 full_nxt[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_full <= 2'b00;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      done_err  <= 1'b0;
    end else begin
      bank_full <= full_nxt;
      if (fin) wr_bank <= ~wr_bank;
      if (dec_done) begin
        if (dec_vld) rd_bank  <= ~rd_bank;
        else         done_err <= 1'b1;
      end
    end
  end

  // A full bank is never refilled, so completing a fill can never hit the bank being freed.
  a_no_same_bank: assert property (@(posedge clk) disable iff (!rst_n)
    !(fin && dec_done && dec_vld && (wr_bank == rd_bank)));

endmodule

// File: rtl/ldpc_fetch.sv
// Requests codewords from the bit de-interleaver and writes them into a two-bank
// codeword SRAM, handing each completed bank to the LDPC decoder.
module ldpc_fetch import ldpc_fetch_pkg::*; #(
  parameter int WID  = WID_DEF,
  parameter int N_CW = N_CW_DEF,
  parameter int AW   = AW_DEF,
  parameter int TMO  = TMO_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           bidin_rdy,
  input  logic           bidin_ena_out,
  input  logic [WID-1:0] bidin_dout,
  output logic           ldpc_req,
  output logic           ldpc_fin,
  output logic           buf_wr,
  output logic           buf_bank,
  output logic [AW-1:0]  buf_addr,
  output logic [WID-1:0] buf_din,
  output logic           dec_vld,
  output logic           dec_bank,
  input  logic           dec_done,
  output logic [7:0]     cw_cnt,
  output logic [2:0]     err
);

  localparam int IW = $clog2(TMO + 1);

  state_t        state, state_nxt;
  logic [AW-1:0] cnt;
  logic [IW-1:0] idle;
  logic          wr_bank, wr_full, fin, tmo_hit;
  logic          tmo_err, ovr_err, done_err;

  assign fin      = (state == FIN);
  assign buf_bank = buf_wr & wr_bank;

  always_comb begin
    err           = 3'b000;
    err[ERR_TMO]  = tmo_err;
    err[ERR_OVR]  = ovr_err;
    err[ERR_DONE] = done_err;
  end

  ldpc_bank_ctrl u_bank_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .fin      (fin),
    .dec_done (dec_done),
    .wr_bank  (wr_bank),
    .wr_full  (wr_full),
    .rd_bank  (dec_bank),
    .dec_vld  (dec_vld),
    .done_err (done_err)
  );

  // Write port is combinational from the incoming beat so the SRAM sees zero added latency.
  always_comb begin
    state_nxt = state;
    ldpc_req  = 1'b0;
    ldpc_fin  = 1'b0;
    buf_wr    = 1'b0;
    buf_addr  = '0;
    buf_din   = '0;
    tmo_hit   = 1'b0;
    unique case (state)
      IDLE: if (bidin_rdy && !wr_full) state_nxt = REQ;
      REQ: begin
        ldpc_req  = 1'b1;
        state_nxt = FILL;
      end
      FILL: begin
        if (bidin_ena_out) begin
          buf_wr   = 1'b1;
          buf_addr = cnt;
          buf_din  = bidin_dout;
          if (cnt == AW'(N_CW - 1)) state_nxt = FIN;
        end else if (idle == IW'(TMO - 1)) begin
          tmo_hit   = 1'b1;
          state_nxt = IDLE;
        end
      end
      FIN: begin
        ldpc_fin  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      idle    <= '0;
      cw_cnt  <= '0;
      tmo_err <= 1'b0;
      ovr_err <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state == REQ)
        cnt <= '0;
      else if (buf_wr)
        cnt <= (cnt == AW'(N_CW - 1)) ? '0 : cnt + AW'(1);

      // Counts silent FILL cycles; the timeout fires on the TMO-th one.
      if (state != FILL || bidin_ena_out)
        idle <= '0;
      else if (idle != IW'(TMO))
        idle <= idle + IW'(1);

      if (fin) cw_cnt <= cw_cnt + 8'd1;
      if (tmo_hit) tmo_err <= 1'b1;
      if (bidin_ena_out && state != FILL) ovr_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ldpc_fetch.sv
// Self-checking bench for ldpc_fetch: randomized codeword streams checked against a
// counting model of the ping-pong banks (completions vs. frees).
module tb_ldpc_fetch;

  localparam int WID  = 6;
  localparam int N_CW = 9216;
  localparam int AW   = 14;
  localparam int TMO  = 15;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           bidin_rdy = 1'b0;
  logic           bidin_ena_out = 1'b0;
  logic [WID-1:0] bidin_dout = '0;
  logic           dec_done = 1'b0;
  logic           ldpc_req, ldpc_fin, buf_wr, buf_bank, dec_vld, dec_bank;
  logic [AW-1:0]  buf_addr;
  logic [WID-1:0] buf_din;
  logic [7:0]     cw_cnt;
  logic [2:0]     err;

  int n_vec = 0;
  int n_err = 0;

  // Model: codewords completed and banks freed since reset; sticky error bits.
  int       m_done  = 0;
  int       m_freed = 0;
  logic [2:0] m_err = 3'b000;

  always #5 clk = ~clk;

  ldpc_fetch #(.WID(WID), .N_CW(N_CW), .AW(AW), .TMO(TMO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bidin_rdy     (bidin_rdy),
    .bidin_ena_out (bidin_ena_out),
    .bidin_dout    (bidin_dout),
    .ldpc_req      (ldpc_req),
    .ldpc_fin      (ldpc_fin),
    .buf_wr        (buf_wr),
    .buf_bank      (buf_bank),
    .buf_addr      (buf_addr),
    .buf_din       (buf_din),
    .dec_vld       (dec_vld),
    .dec_bank      (dec_bank),
    .dec_done      (dec_done),
    .cw_cnt        (cw_cnt),
    .err           (err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bidin_rdy = 1'b0;
    bidin_ena_out = 1'b0;
    dec_done = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    m_done = 0;
    m_freed = 0;
    m_err = 3'b000;
  endtask

  task automatic request_cw(input string tag);
    bidin_rdy = 1'b1;
    #2;
    n_vec++;
    if (ldpc_req !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL %s req_early: got %b want 0", tag, ldpc_req);
    end
    step();
    #2;
    n_vec++;
    if (ldpc_req !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL %s req_pulse: got %b want 1", tag, ldpc_req);
    end
    bidin_rdy = 1'b0;
    step();
  endtask

  // Offers nvals values; each beat preceded by up to maxgap idle cycles at pct% duty.
  task automatic fill_cw(input string tag, input int nvals, input int pct, input int maxgap,
                         input bit addr_data);
    int gap;
    logic [WID-1:0] d;
    for (int v = 0; v < nvals; v++) begin
      gap = 0;
      while (gap < maxgap && $urandom_range(99, 0) >= pct) begin
        bidin_ena_out = 1'b0;
        bidin_dout = WID'($urandom);
        #2;
        n_vec++;
        if (buf_wr !== 1'b0 || ldpc_fin !== 1'b0) begin
          n_err++;
          $display("[TB] FAIL %s gap_idle v=%0d: got wr=%b fin=%b want 0 0", tag, v, buf_wr, ldpc_fin);
        end
        step();
        gap++;
      end
      d = addr_data ? WID'(v) : WID'($urandom);
      bidin_ena_out = 1'b1;
      bidin_dout = d;
      #2;
      n_vec++;
      if ({buf_wr, buf_bank, buf_addr, buf_din, ldpc_fin, ldpc_req} !==
          {1'b1, 1'(m_done % 2), AW'(v), d, 1'b0, 1'b0}) begin
        n_err++;
        $display("[TB] FAIL %s write v=%0d: got wr=%b bank=%b addr=%0d din=%h fin=%b want 1 %0d %0d %h 0",
                 tag, v, buf_wr, buf_bank, buf_addr, buf_din, ldpc_fin, m_done % 2, v, d);
      end
      step();
    end
    bidin_ena_out = 1'b0;
  endtask

  task automatic finish_cw(input string tag);
    #2;
    n_vec++;
    if (ldpc_fin !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL %s fin_pulse: got %b want 1", tag, ldpc_fin);
    end
    m_done++;
    step();
    #2;
    n_vec++;
    if ({ldpc_fin, dec_vld, dec_bank, cw_cnt, err} !==
        {1'b0, 1'(m_done > m_freed), 1'(m_freed % 2), 8'(m_done % 256), m_err}) begin
      n_err++;
      $display("[TB] FAIL %s after_fin: got fin=%b vld=%b bank=%b cw=%0d err=%b want 0 %0d %0d %0d %b",
               tag, ldpc_fin, dec_vld, dec_bank, cw_cnt, err,
               m_done > m_freed, m_freed % 2, m_done % 256, m_err);
    end
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bidin_rdy = 1'($urandom);
      bidin_ena_out = 1'($urandom);
      bidin_dout = WID'($urandom);
      dec_done = 1'($urandom);
      step();
      #2;
      n_vec++;
      if ({ldpc_req, ldpc_fin, buf_wr, buf_bank, buf_addr, buf_din, dec_vld, dec_bank, cw_cnt, err} !== '0) begin
        n_err++;
        $display("[TB] FAIL reset_outputs: got req=%b fin=%b wr=%b bank=%b addr=%0d din=%h vld=%b dbank=%b cw=%0d err=%b want all 0",
                 ldpc_req, ldpc_fin, buf_wr, buf_bank, buf_addr, buf_din, dec_vld, dec_bank, cw_cnt, err);
      end
    end
    do_reset();
  endtask

  task automatic test_basic();
    do_reset();
    request_cw("basic");
    fill_cw("basic", N_CW, 100, 0, 1'b1);
    finish_cw("basic");
  endtask

  task automatic test_ping_pong();
    do_reset();
    request_cw("pp0");
    fill_cw("pp0", N_CW, 100, 0, 1'b0);
    finish_cw("pp0");
    request_cw("pp1");
    fill_cw("pp1", N_CW, 100, 0, 1'b0);
    finish_cw("pp1");
    bidin_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #2;
      n_vec++;
      if ({ldpc_req, dec_vld, dec_bank} !== 3'b010) begin
        n_err++;
        $display("[TB] FAIL pp_both_full c=%0d: got req=%b vld=%b bank=%b want 0 1 0", i, ldpc_req, dec_vld, dec_bank);
      end
      step();
    end
    dec_done = 1'b1;
    step();
    dec_done = 1'b0;
    m_freed++;
    #2;
    n_vec++;
    if ({ldpc_req, dec_vld, dec_bank} !== 3'b011) begin
      n_err++;
      $display("[TB] FAIL pp_freed: got req=%b vld=%b bank=%b want 0 1 1", ldpc_req, dec_vld, dec_bank);
    end
    step();
    #2;
    n_vec++;
    if (ldpc_req !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL pp_third_req: got %b want 1", ldpc_req);
    end
    bidin_rdy = 1'b0;
    step();
  endtask

  // Continues the third ping-pong codeword (bank 0) and resets it partway through.
  task automatic test_reset_mid_fill();
    fill_cw("mid", 5000, 100, 0, 1'b0);
    rst_n = 1'b0;
    bidin_ena_out = 1'b1;
    bidin_dout = WID'($urandom);
    step();
    #2;
    n_vec++;
    if ({ldpc_req, ldpc_fin, buf_wr, buf_bank, buf_addr, buf_din, dec_vld, dec_bank, cw_cnt, err} !== '0) begin
      n_err++;
      $display("[TB] FAIL mid_reset_outputs: got req=%b fin=%b wr=%b addr=%0d vld=%b dbank=%b cw=%0d err=%b want all 0",
               ldpc_req, ldpc_fin, buf_wr, buf_addr, dec_vld, dec_bank, cw_cnt, err);
    end
    bidin_ena_out = 1'b0;
    rst_n = 1'b1;
    m_done = 0;
    m_freed = 0;
    m_err = 3'b000;
    step();
    request_cw("fresh");
    fill_cw("fresh", N_CW, 100, 0, 1'b0);
    finish_cw("fresh");
  endtask

  task automatic test_gapped();
    do_reset();
    request_cw("gap");
    fill_cw("gap", N_CW, 30, 3, 1'b0);
    finish_cw("gap");
  endtask

  task automatic test_timeout();
    do_reset();
    request_cw("tmo");
    fill_cw("tmo", 100, 100, 0, 1'b0);
    for (int k = 1; k <= TMO; k++) begin
      step();
      if (k == TMO - 1) begin
        #2;
        n_vec++;
        if ({err, ldpc_fin} !== 4'b0000) begin
          n_err++;
          $display("[TB] FAIL tmo_early: got err=%b fin=%b want 000 0", err, ldpc_fin);
        end
      end
    end
    m_err[2] = 1'b1;
    #2;
    n_vec++;
    if ({err, ldpc_fin, dec_vld, cw_cnt} !== {m_err, 1'b0, 1'b0, 8'd0}) begin
      n_err++;
      $display("[TB] FAIL tmo_flag: got err=%b fin=%b vld=%b cw=%0d want %b 0 0 0", err, ldpc_fin, dec_vld, cw_cnt, m_err);
    end
    step();
    request_cw("tmo_retry");
    fill_cw("tmo_retry", 50, 100, 0, 1'b1);
  endtask

  task automatic test_errors();
    do_reset();
    bidin_ena_out = 1'b1;
    bidin_dout = WID'($urandom);
    #2;
    n_vec++;
    if (buf_wr !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL ovr_no_write: got %b want 0", buf_wr);
    end
    step();
    bidin_ena_out = 1'b0;
    m_err[1] = 1'b1;
    #2;
    n_vec++;
    if (err !== m_err) begin
      n_err++;
      $display("[TB] FAIL ovr_flag: got %b want %b", err, m_err);
    end
    dec_done = 1'b1;
    step();
    dec_done = 1'b0;
    m_err[0] = 1'b1;
    #2;
    n_vec++;
    if ({err, dec_vld, dec_bank} !== {m_err, 1'b0, 1'b0}) begin
      n_err++;
      $display("[TB] FAIL done_err: got err=%b vld=%b bank=%b want %b 0 0", err, dec_vld, dec_bank, m_err);
    end
    step();
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_basic();
    test_errors();
    test_timeout();
    test_ping_pong();
    test_reset_mid_fill();
    test_gapped();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
